alu_mdu_ctrl: RTL and testbench
===============================

ALU_MDU_CTRL -- requirements
Module: alu_mdu_ctrl

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits; legal values 8..64, even.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ALUOp  input  2  main-decoder class: 00 add-type, 01 branch, 10 R/I arithmetic, 11 LUI.
REQ-005 op5  input  1  opcode bit 5; 1 = register-register form.
REQ-006 func3  input  3  instruction funct3.
REQ-007 func7  input  7  instruction funct7.
REQ-008 valid_in  input  1  decode inputs and operands valid this cycle.
REQ-009 kill  input  1  pipeline flush; aborts any MDU operation.
REQ-010 srcA, srcB  input  XLEN each  MDU operands rs1, rs2.
REQ-011 ALUControl  output  4  combinational ALU opcode.
REQ-012 mdu_sel  output  1  combinational; current instruction is M-extension.
REQ-013 stall  output  1  combinational; hold the execute stage this cycle.
REQ-014 result_valid  output  1  registered; mdu_result valid for exactly this cycle.
REQ-015 mdu_result  output  XLEN  registered MDU result.

Function
REQ-016 ALUControl encodings: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, MOV 1001, SLTU 1010.
REQ-017 ALUOp 00 -> ADD; 01 -> SUB; 11 -> MOV.
REQ-018 ALUOp 10, non-M: func3 000 -> SUB if op5 & func7[5], else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 -> SRA if func7[5], else SRL; 110 OR; 111 AND.
REQ-019 M-op = ALUOp 10 & op5 & func7 == 0000001; mdu_sel = M-op; ALUControl = ADD when M-op.
REQ-020 M-op func3: 000 MUL (low XLEN), 001 MULH (s*s high), 010 MULHSU (s*u high), 011 MULHU (u*u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-021 FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-022 IDLE -> MUL or DIV when valid_in & M-op & !kill; srcA, srcB, func3 latched on that edge; operands of signed ops converted to magnitude, result sign recorded.
REQ-023 MUL/DIV: radix-2 shift-add multiply / restoring divide, one step per cycle, iteration counter from 0 to XLEN-1; at count XLEN-1 -> DONE.
REQ-024 DONE: result_valid = 1, mdu_result holds sign-corrected result; DONE -> IDLE unconditionally next cycle.
REQ-025 Latency: issue at edge N, result_valid high during cycle N+XLEN+1; fixed, independent of operand values.
REQ-026 stall = (valid_in & M-op & state == IDLE) | state == MUL | state == DIV; stall = 0 in DONE.
REQ-027 valid_in while MUL/DIV ignored; latched operands unchanged.
REQ-028 Divide by zero: quotient all ones, remainder = dividend (DIV/DIVU/REM/REMU); same latency.
REQ-029 Signed overflow (dividend = -2^(XLEN-1), divisor = -1): DIV quotient = dividend, REM remainder = 0; same latency.
REQ-030 kill in any state: next state IDLE, result_valid not asserted, stall deasserts next cycle; kill has priority over issue.
REQ-031 Back-to-back: M-op presented in DONE cycle with valid_in is not issued; issue occurs from IDLE the following cycle.

Reset
REQ-032 reset asserted: state IDLE, counter 0, result_valid 0, mdu_result 0, internal operand/accumulator registers 0, immediately, independent of clk.
REQ-033 reset mid-operation discards the operation; no result_valid after release.
REQ-034 Combinational outputs follow inputs during reset; stall reflects IDLE state.

Verification (XLEN=32)
REQ-035 ALUOp 10, op5 1, func3 000, func7 0100000 -> ALUControl 0001, mdu_sel 0; func7 0000000 -> 0000; func3 101, func7 0100000 -> 1000.
REQ-036 MUL, srcA 0xFFFFFFFF, srcB 0x00000002 issued at edge 0 -> stall high cycles 0..32, result_valid in cycle 33 with 0xFFFFFFFE; MULHU same operands -> 0x00000001; MULH -> 0xFFFFFFFF.
REQ-037 DIV srcA 0xFFFFFFF9 (-7), srcB 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
REQ-038 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; latency 33.
REQ-039 kill asserted 5 cycles after issue -> state IDLE next cycle, no result_valid within 40 cycles, new MUL 3*4 then returns 12.
REQ-040 reset pulse 10 cycles into DIVU -> result_valid 0, mdu_result 0 immediately; no result after release.

Source files
------------

// File: rtl/alu_mdu_ctrl.sv
// ALU control decoder plus a sequential multiply/divide unit (RV32M/RV64M style).
// Multiply is radix-2 shift-add and divide is restoring; both take XLEN steps,
// so the latency is fixed regardless of operand values.
`timescale 1ns/1ps
module alu_mdu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ALUOp,
  input  logic            op5,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic            valid_in,
  input  logic            kill,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic [3:0]      ALUControl,
  output logic            mdu_sel,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] mdu_result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_MOV  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic              neg_res, neg_rem, div_zero;
  // opa: shifted multiplicand (mul) or dividend/quotient shift register (div)
  // opb: multiplier (mul) or divisor (div)
  // acc: product (mul) or partial remainder in the low XLEN+1 bits (div)
  logic [2*XLEN-1:0] opa, acc;
  logic [XLEN-1:0]   opb;

  logic              m_op, issue, last_step;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] mul_acc_next, prod;
  logic [XLEN:0]     rem_shift, rem_diff, rem_next;
  logic              rem_ok;
  logic [XLEN-1:0]   quo_next, quo_fix, rem_fix, mul_res, div_res, final_res;

  assign m_op      = (ALUOp == 2'b10) & op5 & (func7 == 7'b0000001);
  assign mdu_sel   = m_op;
  assign issue     = (state == IDLE) & valid_in & m_op & ~kill;
  assign last_step = (count == CW'(XLEN - 1));
  assign stall     = (valid_in & m_op & (state == IDLE)) | (state == MUL) | (state == DIV);

  // ALU opcode decode from the main-decoder class and funct fields
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      2'b00: ALUControl = ALU_ADD;
      2'b01: ALUControl = ALU_SUB;
      2'b11: ALUControl = ALU_MOV;
      default: begin
        if (!m_op) begin
          case (func3)
            3'b000: ALUControl = (op5 & func7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: ALUControl = ALU_SLL;
            3'b010: ALUControl = ALU_SLT;
            3'b011: ALUControl = ALU_SLTU;
            3'b100: ALUControl = ALU_XOR;
            3'b101: ALUControl = func7[5] ? ALU_SRA : ALU_SRL;
            3'b110: ALUControl = ALU_OR;
            default: ALUControl = ALU_AND;
          endcase
        end
      end
    endcase
  end

  // Operand signedness and magnitudes for the op being issued
  always_comb begin
    a_signed = func3[2] ? ~func3[0] : ((func3 == 3'b001) || (func3 == 3'b010));
    b_signed = func3[2] ? ~func3[0] : (func3 == 3'b001);
    a_neg    = a_signed & srcA[XLEN-1];
    b_neg    = b_signed & srcB[XLEN-1];
    a_mag    = a_neg ? -srcA : srcA;
    b_mag    = b_neg ? -srcB : srcB;
  end

  // One iteration of shift-add multiply and restoring divide, plus sign fix-up of the final step
  always_comb begin
    mul_acc_next = opb[0] ? (acc + opa) : acc;
    rem_shift    = {acc[XLEN-1:0], opa[XLEN-1]};
    rem_diff     = rem_shift - {1'b0, opb};
    rem_ok       = ~rem_diff[XLEN];
    rem_next     = rem_ok ? rem_diff : rem_shift;
    quo_next     = {opa[XLEN-2:0], rem_ok};
    prod         = neg_res ? -mul_acc_next : mul_acc_next;
    mul_res      = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo_fix      = div_zero ? '1 : (neg_res ? -quo_next : quo_next);
    rem_fix      = neg_rem ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
    div_res      = op_q[1] ? rem_fix : quo_fix;
    final_res    = (state == MUL) ? mul_res : div_res;
  end

  // Next-state logic; kill always wins and returns to IDLE
  always_comb begin
    state_next = state;
    if (kill) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (valid_in && m_op) state_next = func3[2] ? DIV : MUL;
        MUL,
        DIV:     if (last_step) state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath: latch operands on issue, then step once per cycle; result registered on the last step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      op_q         <= '0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      opa          <= '0;
      opb          <= '0;
      acc          <= '0;
      result_valid <= 1'b0;
      mdu_result   <= '0;
    end else begin
      result_valid <= 1'b0;
      if (issue) begin
        count    <= '0;
        op_q     <= func3;
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
        div_zero <= (srcB == '0);
        opa      <= {{XLEN{1'b0}}, a_mag};
        opb      <= b_mag;
        acc      <= '0;
      end else if (state == MUL || state == DIV) begin
        count <= count + 1'b1;
        if (state == MUL) begin
          acc <= mul_acc_next;
          opa <= opa << 1;
          opb <= opb >> 1;
        end else begin
          acc <= {{(XLEN-1){1'b0}}, rem_next};
          opa <= {{XLEN{1'b0}}, quo_next};
        end
        if (last_step && !kill) begin
          result_valid <= 1'b1;
          mdu_result   <= final_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Scoreboard bench for alu_mdu_ctrl: the driver pushes expected results with
// their expected cycle, a negedge monitor pops and compares on result_valid.
`timescale 1ns/1ps
module tb_alu_mdu_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      ALUOp;
  logic            op5;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic            valid_in;
  logic            kill;
  logic [XLEN-1:0] srcA, srcB;
  logic [3:0]      ALUControl;
  logic            mdu_sel, stall, result_valid;
  logic [XLEN-1:0] mdu_result;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  alu_mdu_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .op5(op5), .func3(func3), .func7(func7),
    .valid_in(valid_in), .kill(kill), .srcA(srcA), .srcB(srcB),
    .ALUControl(ALUControl), .mdu_sel(mdu_sel), .stall(stall),
    .result_valid(result_valid), .mdu_result(mdu_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every result_valid must match the oldest expected entry in value and cycle
  always @(negedge clk) begin
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got result_valid with 0x%08h at cycle %0d, none expected", mdu_result, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("mdu_result", mdu_result, e.val);
        check_output("latency_cycle", cyc, e.cyc);
        check_output("stall_in_done", {31'b0, stall}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_dec(input logic [1:0] aop, input logic o5, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [3:0] ctl, input logic sel);
    ALUOp = aop; op5 = o5; func3 = f3; func7 = f7;
    #1;
    check_output("alu_control", {28'b0, ALUControl}, {28'b0, ctl});
    check_output("mdu_sel", {31'b0, mdu_sel}, {31'b0, sel});
  endtask

  // Present an M-op in an IDLE cycle, issue it on the next edge and optionally record its expected result
  task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input bit want);
    ALUOp = 2'b10; op5 = 1'b1; func7 = 7'b0000001; func3 = f3;
    srcA = a; srcB = b; valid_in = 1'b1;
    #1;
    check_output("stall_issue", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    if (want) exp_q.push_back('{exp, cyc + XLEN});
    check_output("stall_busy", {31'b0, stall}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout: %0d results still pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; ALUOp = 2'b00; op5 = 1'b0; func3 = 3'b000; func7 = 7'b0;
    valid_in = 1'b0; kill = 1'b0; srcA = '0; srcB = '0;
    #1;
    check_output("reset_stall", {31'b0, stall}, 32'd0);
    check_output("reset_valid", {31'b0, result_valid}, 32'd0);
    check_output("reset_result", mdu_result, 32'd0);
    ALUOp = 2'b10; op5 = 1'b1; func7 = 7'b0000001; valid_in = 1'b1;
    #1;
    check_output("reset_stall_follow", {31'b0, stall}, 32'd1);
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] decoder vectors");
    check_dec(2'b10, 1'b1, 3'b000, 7'b0100000, 4'b0001, 1'b0);
    check_dec(2'b10, 1'b1, 3'b000, 7'b0000000, 4'b0000, 1'b0);
    check_dec(2'b10, 1'b1, 3'b101, 7'b0100000, 4'b1000, 1'b0);
    check_dec(2'b10, 1'b0, 3'b000, 7'b0100000, 4'b0000, 1'b0);
    check_dec(2'b10, 1'b1, 3'b101, 7'b0000000, 4'b0111, 1'b0);
    check_dec(2'b10, 1'b1, 3'b001, 7'b0000000, 4'b0110, 1'b0);
    check_dec(2'b10, 1'b1, 3'b010, 7'b0000000, 4'b0101, 1'b0);
    check_dec(2'b10, 1'b1, 3'b011, 7'b0000000, 4'b1010, 1'b0);
    check_dec(2'b10, 1'b1, 3'b100, 7'b0000000, 4'b0100, 1'b0);
    check_dec(2'b10, 1'b1, 3'b110, 7'b0000000, 4'b0011, 1'b0);
    check_dec(2'b10, 1'b1, 3'b111, 7'b0000000, 4'b0010, 1'b0);
    check_dec(2'b00, 1'b1, 3'b111, 7'b0100000, 4'b0000, 1'b0);
    check_dec(2'b01, 1'b0, 3'b001, 7'b0000000, 4'b0001, 1'b0);
    check_dec(2'b11, 1'b0, 3'b000, 7'b0000000, 4'b1001, 1'b0);
    check_dec(2'b10, 1'b1, 3'b100, 7'b0000001, 4'b0000, 1'b1);
    check_dec(2'b10, 1'b0, 3'b000, 7'b0000001, 4'b0000, 1'b0);
    @(posedge clk); #1;

    $display("[TB] multiply vectors");
    apply_stimulus(3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1); wait_idle();
    apply_stimulus(3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b1); wait_idle();
    apply_stimulus(3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b1); wait_idle();
    apply_stimulus(3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b1); wait_idle();
    apply_stimulus(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1); wait_idle();

    $display("[TB] divide vectors");
    apply_stimulus(3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b1); wait_idle();
    apply_stimulus(3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b1); wait_idle();
    apply_stimulus(3'b101, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b1); wait_idle();
    apply_stimulus(3'b111, 32'h00000007, 32'h00000000, 32'h00000007, 1'b1); wait_idle();
    apply_stimulus(3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b1); wait_idle();
    apply_stimulus(3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b1); wait_idle();
    apply_stimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1); wait_idle();
    apply_stimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1); wait_idle();
    apply_stimulus(3'b101, 32'd100, 32'd7, 32'd14, 1'b1); wait_idle();
    apply_stimulus(3'b111, 32'd100, 32'd7, 32'd2, 1'b1); wait_idle();

    $display("[TB] back-to-back issue from DONE");
    apply_stimulus(3'b000, 32'd5, 32'd6, 32'd30, 1'b1);
    repeat (XLEN) begin @(posedge clk); #1; end
    ALUOp = 2'b10; op5 = 1'b1; func7 = 7'b0000001; func3 = 3'b000;
    srcA = 32'd7; srcB = 32'd8; valid_in = 1'b1;
    #1;
    check_output("stall_done_cycle", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    apply_stimulus(3'b000, 32'd7, 32'd8, 32'd56, 1'b1);
    wait_idle();

    $display("[TB] kill mid-multiply");
    apply_stimulus(3'b000, 32'd9, 32'd9, 32'd81, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    kill = 1'b1;
    #1;
    check_output("stall_before_kill", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    kill = 1'b0;
    check_output("stall_after_kill", {31'b0, stall}, 32'd0);
    repeat (40) begin @(posedge clk); #1; end
    apply_stimulus(3'b000, 32'd3, 32'd4, 32'd12, 1'b1);
    wait_idle();

    $display("[TB] reset mid-divide");
    apply_stimulus(3'b101, 32'd1000, 32'd3, 32'd333, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    #1 reset = 1'b1;
    #1;
    check_output("reset_mid_valid", {31'b0, result_valid}, 32'd0);
    check_output("reset_mid_result", mdu_result, 32'd0);
    check_output("reset_mid_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (45) begin @(posedge clk); #1; end
    check_output("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
